imem_access_arbiter: RTL
========================

Name: imem_access_arbiter

Overview:
- Sits between the single-port synchronous instruction RAM and two requesters: the core fetch unit and the program loader (debug/boot).
- Sequences boot: the loader owns the memory until it signals completion.
- Arbitrates the one port cycle-by-cycle once the core is running.
- Tracks the RAM's 1-cycle registered read latency and routes each read response to the requester that issued it.

Parameters:
- WIDTH, 32, data word width.
- ADDR_W, 8, word address width; RAM depth is 2**ADDR_W.
- BOOT_HOLD, 1, 1 = start in BOOT state with fetch blocked; 0 = start in RUN.
- MAX_BURST, 4, maximum consecutive loader grants while fetch is waiting; range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- clear  in  1  asynchronous active-low reset. Shared with the RAM.
- fetch_req  in  1  fetch read request.
- fetch_addr  in  ADDR_W  fetch word address.
- fetch_gnt  out  1  fetch request accepted this cycle.
- fetch_rvalid  out  1  mem_dout holds data for the fetch granted in the previous cycle.
- load_req  in  1  loader request.
- load_we  in  1  1 = write, 0 = read.
- load_addr  in  ADDR_W  loader word address.
- load_wdata  in  WIDTH  loader write data.
- load_gnt  out  1  loader request accepted this cycle.
- load_rvalid  out  1  mem_dout holds data for the loader read granted in the previous cycle.
- boot_done  in  1  single-cycle pulse from loader: image complete.
- core_hold  out  1  holds the core in reset/stall while in BOOT.
- mem_addr  out  ADDR_W  to RAM ADDR.
- mem_din  out  WIDTH  to RAM DIN.
- mem_wren  out  1  to RAM wren.
- mem_dout  in  WIDTH  from RAM DOUT, registered, valid the cycle after the address.

Behaviour:
- Reset (clear=0, asynchronous):
  - state = BOOT if BOOT_HOLD=1, else RUN.
  - core_hold = BOOT_HOLD.
  - burst_cnt = 0.
  - resp_tag = NONE.
  - fetch_rvalid = 0, load_rvalid = 0.
- Grants are combinational from the request inputs, state and burst_cnt. At most one grant per cycle.
- mem_addr / mem_din / mem_wren:
  - Follow the granted requester.
  - With no grant: mem_addr = fetch_addr, mem_wren = 0.
  - mem_wren = load_gnt & load_we. It is never 1 without load_gnt.
- State BOOT:
  - fetch_gnt = 0.
  - load_gnt = load_req.
  - core_hold = 1.
  - boot_done=1 → RUN at the next edge; core_hold goes 0 in that same edge.
  - A loader request in the boot_done cycle is still granted.
- State RUN, arbitration:
  - Loader has priority.
  - If load_req & fetch_req and burst_cnt == MAX_BURST, fetch wins that cycle.
  - Otherwise load_gnt = load_req and fetch_gnt = fetch_req & ~load_req.
- burst_cnt:
  - Increments (saturating at MAX_BURST) on each cycle with load_gnt & fetch_req.
  - Clears on any fetch_gnt or any cycle with fetch_req=0.
  - A waiting fetch is therefore granted within MAX_BURST+1 cycles.
- boot_done in RUN is ignored. There is no return to BOOT except by reset.
- Response tracking:
  - resp_tag is registered each edge: FETCH if fetch_gnt; LOAD if load_gnt & ~load_we; else NONE.
  - fetch_rvalid = (resp_tag==FETCH); load_rvalid = (resp_tag==LOAD).
  - Exactly 1-cycle latency.
  - Loader writes produce no rvalid, although the RAM returns the old word that cycle.
- Read-after-write: a write granted at cycle t is visible to a read granted at cycle t+1 or later. No forwarding is needed.
- Reset mid-operation:
  - Outstanding responses are dropped (rvalid=0). The RAM DOUT also clears to 0.
  - A write granted in the reset cycle is not guaranteed.
- Requesters must hold req/addr/data stable until granted. Addresses wrap naturally at 2**ADDR_W.

Test Plan:
- Reset with BOOT_HOLD=1, fetch_req=1 constantly → core_hold=1, fetch_gnt=0 for 20 cycles, mem_wren=0, both rvalid=0.
- BOOT: loader writes 0x00100093 to addr 0 and 0x00200113 to addr 1, then pulses boot_done → core_hold falls at that edge. Next cycle fetch of addr 0 granted; one cycle later fetch_rvalid=1, mem_dout=0x00100093.
- RUN, loader write then read: write 0xDEADBEEF to addr 5 at cycle t, read addr 5 at t+1 → load_rvalid=1 at t+2 with 0xDEADBEEF. fetch_rvalid=0 throughout; no rvalid on the write.
- RUN contention with MAX_BURST=4, load_req and fetch_req both held high → load_gnt for 4 cycles, fetch_gnt on cycle 5, then loader again. The pattern repeats and fetch_rvalid follows each fetch_gnt by 1 cycle.
- Address wrap: fetch addr 255 then addr 0 → two consecutive grants and rvalids with correct words, no stall.
- Assert clear while a fetch read is outstanding → fetch_rvalid=0 on the next cycle. State returns to BOOT, burst_cnt=0.

Source files
------------

// File: rtl/imem_access_arbiter.sv
// Single-port instruction RAM arbiter: loader owns the port during boot, then
// loader-priority arbitration with a bounded burst so fetch is never starved.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_BOOT | core held, only the loader may access the RAM
// ST_RUN  | core running, loader priority, fetch forced after MAX_BURST
module imem_access_arbiter #(
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 8,
  parameter int BOOT_HOLD = 1,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  input  logic              load_req,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [WIDTH-1:0]  load_wdata,
  output logic              load_gnt,
  output logic              load_rvalid,
  input  logic              boot_done,
  output logic              core_hold,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_din,
  output logic              mem_wren,
  input  logic [WIDTH-1:0]  mem_dout
);

  typedef enum logic {ST_BOOT, ST_RUN} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_FETCH, TAG_LOAD} tag_t;

  localparam state_t     ST_RESET  = (BOOT_HOLD != 0) ? ST_BOOT : ST_RUN;
  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  state_t     state, state_nxt;
  tag_t       resp_tag, tag_nxt;
  logic [3:0] burst_cnt, burst_nxt;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state     <= ST_RESET;
      burst_cnt <= '0;
      resp_tag  <= TAG_NONE;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      resp_tag  <= tag_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fetch_gnt = 1'b0;
    load_gnt  = 1'b0;
    case (state)
      ST_BOOT: begin
        load_gnt = load_req;
        if (boot_done) state_nxt = ST_RUN;
      end
      default: begin
        // Fetch has waited through a full loader burst: it takes this slot.
        if (load_req && fetch_req && (burst_cnt == BURST_MAX)) begin
          fetch_gnt = 1'b1;
        end else begin
          load_gnt  = load_req;
          fetch_gnt = fetch_req & ~load_req;
        end
      end
    endcase
  end

  always_comb begin
    burst_nxt = burst_cnt;
    if (fetch_gnt || !fetch_req) begin
      burst_nxt = '0;
    end else if (load_gnt && (burst_cnt != BURST_MAX)) begin
      burst_nxt = burst_cnt + 4'd1;
    end
  end

  // Writes are tagged NONE: the RAM still returns the old word, nobody wants it.
  always_comb begin
    tag_nxt = TAG_NONE;
    if (fetch_gnt) begin
      tag_nxt = TAG_FETCH;
    end else if (load_gnt && !load_we) begin
      tag_nxt = TAG_LOAD;
    end
  end

  assign fetch_rvalid = (resp_tag == TAG_FETCH);
  assign load_rvalid  = (resp_tag == TAG_LOAD);
  assign core_hold    = (state == ST_BOOT);

  assign mem_addr = load_gnt ? load_addr : fetch_addr;
  assign mem_din  = load_gnt ? load_wdata : '0;
  assign mem_wren = load_gnt & load_we;

  // mem_dout passes straight to both requesters; rvalid says whose it is.
  logic unused_dout;
  assign unused_dout = ^mem_dout;

endmodule
